// File: rtl/wb_timer.sv
// wb_timer: Wishbone B4 responder for a RISC-V machine timer (clk, rst_n, wb_* responder port, timer_irq mtip out)
module wb_timer #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 5,
  parameter int WAIT_STATES = 0,
  parameter int PRESCALE_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [XLEN-1:0]   wb_dat_i,
  input  logic [XLEN/8-1:0] wb_sel_i,
  output logic [XLEN-1:0]   wb_dat_o,
  output logic              wb_ack_o,
  output logic              timer_irq
);
  localparam int IW = ADDR_W - 2;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state;
  logic [3:0] wcnt;
  logic [IW-1:0] adr_q, idx;
  logic we_q, cur_we, tick, en;
  logic [XLEN-1:0] dat_q, rd_data;
  logic [XLEN/8-1:0] sel_q;
  logic [63:0] mtime, mtimecmp;
  logic [PRESCALE_W-1:0] prescale, presc_cnt;
  logic unused_adr;
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] d, input logic [XLEN/8-1:0] s);
    logic [XLEN-1:0] r;
    r = old;
    for (int i = 0; i < XLEN/8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction
  assign unused_adr = &{1'b0, wb_adr_i[1:0]};
  assign idx = state == IDLE ? wb_adr_i[ADDR_W-1:2] : adr_q;
  assign cur_we = state == IDLE ? wb_we_i : we_q;
  assign tick = en && presc_cnt == prescale;
  assign rd_data = idx == IW'(0) ? mtime[31:0] :
                   idx == IW'(1) ? mtime[63:32] :
                   idx == IW'(2) ? mtimecmp[31:0] :
                   idx == IW'(3) ? mtimecmp[63:32] :
                   idx == IW'(4) ? XLEN'(en) :
                   idx == IW'(5) ? XLEN'(prescale) : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      sel_q     <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      timer_irq <= 1'b0;
      mtime     <= '0;
      mtimecmp  <= '1;
      en        <= 1'b0;
      prescale  <= '0;
      presc_cnt <= '0;
    end else begin
      timer_irq <= mtime >= mtimecmp;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      if (en) presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) mtime <= mtime + 64'd1;
      case (state)
        IDLE: if (wb_cyc_i && wb_stb_i) begin
          adr_q    <= wb_adr_i[ADDR_W-1:2];
          we_q     <= wb_we_i;
          dat_q    <= wb_dat_i;
          sel_q    <= wb_sel_i;
          wcnt     <= '0;
          state    <= WAIT_STATES == 0 ? ACK : WAIT;
          wb_ack_o <= WAIT_STATES == 0;
          wb_dat_o <= WAIT_STATES == 0 && !cur_we ? rd_data : '0;
        end
        WAIT: if (!wb_cyc_i) state <= IDLE;
          else if (wcnt == WS_LAST) begin
            state    <= ACK;
            wb_ack_o <= 1'b1;
            wb_dat_o <= cur_we ? '0 : rd_data;
          end else wcnt <= wcnt + 1'b1;
        ACK: begin
          state <= IDLE;
          // later assignments override the tick update above, so a write drops that tick entirely
          if (we_q && |sel_q) begin
            if (adr_q == IW'(0)) mtime <= {mtime[63:32], merge(mtime[31:0], dat_q, sel_q)};
            if (adr_q == IW'(1)) mtime <= {merge(mtime[63:32], dat_q, sel_q), mtime[31:0]};
            if (adr_q == IW'(2)) mtimecmp <= {mtimecmp[63:32], merge(mtimecmp[31:0], dat_q, sel_q)};
            if (adr_q == IW'(3)) mtimecmp <= {merge(mtimecmp[63:32], dat_q, sel_q), mtimecmp[31:0]};
            if (adr_q == IW'(4) && sel_q[0]) en <= dat_q[0];
            if (adr_q == IW'(5)) begin
              prescale  <= PRESCALE_W'(merge(XLEN'(prescale), dat_q, sel_q));
              presc_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
